// File: rtl/adj_list_streamer.sv
// adj_list_streamer: host-loaded compressed adjacency list (offset table +
// flat edge table). Serves a two-beat seed sequence and streams the
// successors of a requested node one per cycle with a descending counter.
module adj_list_streamer #(
  parameter int unsigned PARAM_NODE_IDX_WIDTH  = 10,
  parameter int unsigned PARAM_COUNTER_WIDTH   = 4,
  parameter int unsigned PARAM_EDGE_ADDR_WIDTH = 12
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             cfg_off_we,
  input  logic [PARAM_NODE_IDX_WIDTH-1:0]  cfg_off_node,
  input  logic [PARAM_EDGE_ADDR_WIDTH-1:0] cfg_off_base,
  input  logic [PARAM_COUNTER_WIDTH-1:0]   cfg_off_deg,
  input  logic                             cfg_edge_we,
  input  logic [PARAM_EDGE_ADDR_WIDTH-1:0] cfg_edge_addr,
  input  logic [PARAM_NODE_IDX_WIDTH-1:0]  cfg_edge_dst,
  input  logic                             cfg_seed_we,
  input  logic [PARAM_NODE_IDX_WIDTH-1:0]  cfg_start_node,
  input  logic [PARAM_NODE_IDX_WIDTH-1:0]  cfg_end_node,
  output logic                             cfg_err,
  input  logic                             seed_req,
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic [PARAM_NODE_IDX_WIDTH-1:0]  req_node,
  output logic                             next_valid,
  input  logic                             next_ready,
  output logic [PARAM_NODE_IDX_WIDTH-1:0]  next_node_idx,
  output logic [PARAM_COUNTER_WIDTH-1:0]   next_node_counter,
  output logic                             next_is_seed,
  output logic                             next_empty
);

  localparam int unsigned NW    = PARAM_NODE_IDX_WIDTH;
  localparam int unsigned CW    = PARAM_COUNTER_WIDTH;
  localparam int unsigned EW    = PARAM_EDGE_ADDR_WIDTH;
  localparam int unsigned NODES = 1 << NW;
  localparam int unsigned EDGES = 1 << EW;

  typedef enum logic [2:0] {
    IDLE,
    SEED_START,
    SEED_END,
    LOOKUP,
    STREAM
  } state_t;

  state_t state_q, state_d;

  // Graph storage (not reset; contents defined by the host load)
  logic [EW-1:0] off_base_mem [NODES];
  logic [CW-1:0] off_deg_mem  [NODES];
  logic [NW-1:0] edge_mem     [EDGES];

  logic [NW-1:0] seed_start_q, seed_end_q;
  logic [EW-1:0] lk_base_q;
  logic [CW-1:0] lk_deg_q;
  logic [EW-1:0] addr_q, addr_d;
  logic [EW-1:0] addr_inc;

  logic          valid_d, seed_d, empty_d, ready_d;
  logic [NW-1:0] idx_d;
  logic [CW-1:0] cnt_d;

  logic cfg_ok, cfg_any, accept, fire, last_beat;

  assign cfg_ok    = (state_q == IDLE) && !seed_req && !req_valid;
  assign cfg_any   = cfg_off_we || cfg_edge_we || cfg_seed_we;
  assign accept    = (state_q == IDLE) && !seed_req && req_valid;
  assign fire      = next_valid && next_ready;
  assign last_beat = next_empty || (next_node_counter == CW'(1));
  assign addr_inc  = addr_q + EW'(1);

  // Table writes and the offset lookup for an accepted request
  always_ff @(posedge clk) begin
    if (cfg_off_we && cfg_ok) begin
      off_base_mem[cfg_off_node] <= cfg_off_base;
      off_deg_mem[cfg_off_node]  <= cfg_off_deg;
    end
    if (cfg_edge_we && cfg_ok) begin
      edge_mem[cfg_edge_addr] <= cfg_edge_dst;
    end
    // Offset read happens on acceptance so LOOKUP can issue the edge read
    if (accept) begin
      lk_base_q <= off_base_mem[req_node];
      lk_deg_q  <= off_deg_mem[req_node];
    end
  end

  // Seed registers and dropped-write error pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      seed_start_q <= '0;
      seed_end_q   <= '0;
      cfg_err      <= 1'b0;
    end else begin
      if (cfg_seed_we && cfg_ok) begin
        seed_start_q <= cfg_start_node;
        seed_end_q   <= cfg_end_node;
      end
      cfg_err <= cfg_any && !cfg_ok;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (seed_req)       state_d = SEED_START;
        else if (req_valid) state_d = LOOKUP;
      end
      SEED_START: if (fire) state_d = SEED_END;
      SEED_END:   if (fire) state_d = IDLE;
      LOOKUP:               state_d = STREAM;
      STREAM:     if (fire && last_beat) state_d = IDLE;
      default:              state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs and the edge address
  always_comb begin
    valid_d = next_valid;
    idx_d   = next_node_idx;
    cnt_d   = next_node_counter;
    seed_d  = next_is_seed;
    empty_d = next_empty;
    addr_d  = addr_q;
    unique case (state_q)
      IDLE: begin
        if (seed_req) begin
          valid_d = 1'b1;
          idx_d   = seed_start_q;
          cnt_d   = '0;
          seed_d  = 1'b1;
          empty_d = 1'b0;
        end
      end
      SEED_START: begin
        if (fire) idx_d = seed_end_q;
      end
      SEED_END: begin
        if (fire) begin
          valid_d = 1'b0;
          idx_d   = '0;
          seed_d  = 1'b0;
        end
      end
      LOOKUP: begin
        valid_d = 1'b1;
        seed_d  = 1'b0;
        if (lk_deg_q == '0) begin
          idx_d   = '0;
          cnt_d   = '0;
          empty_d = 1'b1;
        end else begin
          idx_d   = edge_mem[lk_base_q];
          cnt_d   = lk_deg_q;
          empty_d = 1'b0;
          addr_d  = lk_base_q;
        end
      end
      STREAM: begin
        if (fire) begin
          if (last_beat) begin
            valid_d = 1'b0;
            idx_d   = '0;
            cnt_d   = '0;
            empty_d = 1'b0;
          end else begin
            // Prefetch the following edge so the next beat is ready with no bubble
            addr_d = addr_inc;
            idx_d  = edge_mem[addr_inc];
            cnt_d  = next_node_counter - CW'(1);
          end
        end
      end
      default: ;
    endcase
    ready_d = (state_d == IDLE);
  end

  // Output and address registers
  always_ff @(posedge clk) begin
    if (rst) begin
      next_valid        <= 1'b0;
      next_node_idx     <= '0;
      next_node_counter <= '0;
      next_is_seed      <= 1'b0;
      next_empty        <= 1'b0;
      req_ready         <= 1'b1;
      addr_q            <= '0;
    end else begin
      next_valid        <= valid_d;
      next_node_idx     <= idx_d;
      next_node_counter <= cnt_d;
      next_is_seed      <= seed_d;
      next_empty        <= empty_d;
      req_ready         <= ready_d;
      addr_q            <= addr_d;
    end
  end

endmodule

// File: tb/tb_adj_list_streamer.sv
// Self-checking bench for adj_list_streamer: table-driven node requests with
// a beat scoreboard, plus hand-written seed/stall/busy/reset sequences.
module tb_adj_list_streamer;

  localparam int NW = 10;
  localparam int CW = 4;
  localparam int EW = 12;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cfg_off_we = 1'b0;
  logic [NW-1:0] cfg_off_node = '0;
  logic [EW-1:0] cfg_off_base = '0;
  logic [CW-1:0] cfg_off_deg = '0;
  logic          cfg_edge_we = 1'b0;
  logic [EW-1:0] cfg_edge_addr = '0;
  logic [NW-1:0] cfg_edge_dst = '0;
  logic          cfg_seed_we = 1'b0;
  logic [NW-1:0] cfg_start_node = '0;
  logic [NW-1:0] cfg_end_node = '0;
  logic          cfg_err;
  logic          seed_req = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [NW-1:0] req_node = '0;
  logic          next_valid;
  logic          next_ready = 1'b1;
  logic [NW-1:0] next_node_idx;
  logic [CW-1:0] next_node_counter;
  logic          next_is_seed;
  logic          next_empty;

  adj_list_streamer #(
    .PARAM_NODE_IDX_WIDTH (NW),
    .PARAM_COUNTER_WIDTH  (CW),
    .PARAM_EDGE_ADDR_WIDTH(EW)
  ) dut (
    .clk(clk), .rst(rst),
    .cfg_off_we(cfg_off_we), .cfg_off_node(cfg_off_node),
    .cfg_off_base(cfg_off_base), .cfg_off_deg(cfg_off_deg),
    .cfg_edge_we(cfg_edge_we), .cfg_edge_addr(cfg_edge_addr),
    .cfg_edge_dst(cfg_edge_dst), .cfg_seed_we(cfg_seed_we),
    .cfg_start_node(cfg_start_node), .cfg_end_node(cfg_end_node),
    .cfg_err(cfg_err), .seed_req(seed_req),
    .req_valid(req_valid), .req_ready(req_ready), .req_node(req_node),
    .next_valid(next_valid), .next_ready(next_ready),
    .next_node_idx(next_node_idx), .next_node_counter(next_node_counter),
    .next_is_seed(next_is_seed), .next_empty(next_empty)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NW-1:0] idx;
    logic [CW-1:0] cnt;
    logic          seed;
    logic          empty;
  } beat_t;

  typedef struct {
    int node;
    int base;
    int deg;
    int dst0;
    int step;
  } rec_t;

  beat_t exp_q[$];
  rec_t  tbl[5];
  int    total = 0;
  int    bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void push_beat(input int idx, input int cnt, input bit seed, input bit empty);
    beat_t b;
    b.idx   = idx[NW-1:0];
    b.cnt   = cnt[CW-1:0];
    b.seed  = seed;
    b.empty = empty;
    exp_q.push_back(b);
  endfunction

  function automatic int edge_dst(input rec_t r, input int i);
    return (r.dst0 + r.step * i) % (1 << NW);
  endfunction

  function automatic void push_node(input rec_t r);
    if (r.deg == 0) push_beat(0, 0, 1'b0, 1'b1);
    else for (int i = 0; i < r.deg; i++) push_beat(edge_dst(r, i), r.deg - i, 1'b0, 1'b0);
  endfunction

  // Scoreboard and stall-stability monitor, sampled on the falling edge
  beat_t prev_beat;
  logic  held = 1'b0;
  always @(negedge clk) begin
    beat_t cur;
    beat_t e;
    cur = {next_node_idx, next_node_counter, next_is_seed, next_empty};
    if (rst) begin
      held = 1'b0;
    end else begin
      if (held) check("stall_hold", {15'd0, cur, next_valid}, {15'd0, prev_beat, 1'b1});
      if (next_valid && next_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_beat: got %0h expected no beat (t=%0t)", cur, $time);
        end else begin
          e = exp_q.pop_front();
          check("beat", {16'd0, cur}, {16'd0, e});
        end
      end
      held      = next_valid && !next_ready;
      prev_beat = cur;
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!req_ready && n < 100) begin
      tick();
      n++;
    end
    check("wait_ready_timeout", {31'd0, req_ready}, 32'd1);
  endtask

  task automatic run_req(input int node);
    wait_ready();
    req_node  = node[NW-1:0];
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    check("lookup_no_beat", {31'd0, next_valid}, 32'd0);
    check("lookup_not_ready", {31'd0, req_ready}, 32'd0);
    tick();
    check("first_beat_n2", {31'd0, next_valid}, 32'd1);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    check("drain_left", exp_q.size(), 32'd0);
    exp_q.delete();
    check("idle_ready_after", {30'd0, req_ready, next_valid}, 32'd2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{node: 3, base: 100,  deg: 3,  dst0: 7,    step: 1};
    tbl[1] = '{node: 4, base: 0,    deg: 0,  dst0: 0,    step: 0};
    tbl[2] = '{node: 6, base: 4094, deg: 3,  dst0: 11,   step: 1};
    tbl[3] = '{node: 1, base: 200,  deg: 1,  dst0: 42,   step: 0};
    tbl[4] = '{node: 2, base: 500,  deg: 15, dst0: 1000, step: 5};

    // Reset values
    rst = 1'b1;
    tick(); tick();
    check("rst_outputs",
          {16'd0, next_valid, next_node_idx, next_node_counter, next_is_seed, next_empty},
          32'd0);
    check("rst_cfg_err", {31'd0, cfg_err}, 32'd0);
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    rst = 1'b0;
    tick();
    check("post_rst_ready", {30'd0, req_ready, next_valid}, 32'd2);

    // Host load
    cfg_seed_we = 1'b1; cfg_start_node = 10'd5; cfg_end_node = 10'd9;
    tick();
    cfg_seed_we = 1'b0;
    check("legal_write_no_err", {31'd0, cfg_err}, 32'd0);
    foreach (tbl[k]) begin
      cfg_off_we = 1'b1;
      cfg_off_node = tbl[k].node[NW-1:0];
      cfg_off_base = tbl[k].base[EW-1:0];
      cfg_off_deg  = tbl[k].deg[CW-1:0];
      tick();
      cfg_off_we = 1'b0;
      for (int i = 0; i < tbl[k].deg; i++) begin
        cfg_edge_we   = 1'b1;
        cfg_edge_addr = EW'((tbl[k].base + i) % (1 << EW));
        cfg_edge_dst  = NW'(edge_dst(tbl[k], i));
        tick();
      end
      cfg_edge_we = 1'b0;
    end

    // Seed sequence
    push_beat(5, 0, 1'b1, 1'b0);
    push_beat(9, 0, 1'b1, 1'b0);
    seed_req = 1'b1;
    tick();
    seed_req = 1'b0;
    check("seed_start_n1", {20'd0, next_valid, next_is_seed, next_node_idx}, {20'd0, 2'b11, 10'd5});
    tick();
    check("seed_end_n2", {20'd0, next_valid, next_is_seed, next_node_idx}, {20'd0, 2'b11, 10'd9});
    drain();

    // Table-driven node requests (stream, degree 0, wrap, degree 1, max degree)
    foreach (tbl[k]) begin
      push_node(tbl[k]);
      run_req(tbl[k].node);
      drain();
    end

    // Stall on the second beat for two cycles
    push_node(tbl[0]);
    run_req(3);
    tick();
    next_ready = 1'b0;
    tick();
    check("stall_beat_a", {18'd0, next_node_idx, next_node_counter}, {18'd0, 10'd8, 4'd2});
    tick();
    check("stall_beat_b", {18'd0, next_node_idx, next_node_counter}, {18'd0, 10'd8, 4'd2});
    next_ready = 1'b1;
    drain();

    // Cfg writes while streaming are dropped
    push_node(tbl[0]);
    run_req(3);
    cfg_off_we = 1'b1; cfg_off_node = 10'd3; cfg_off_base = 12'd999; cfg_off_deg = 4'd9;
    cfg_edge_we = 1'b1; cfg_edge_addr = 12'd101; cfg_edge_dst = 10'd500;
    tick();
    cfg_off_we = 1'b0; cfg_edge_we = 1'b0;
    check("cfg_err_pulse", {31'd0, cfg_err}, 32'd1);
    tick();
    check("cfg_err_once", {31'd0, cfg_err}, 32'd0);
    drain();
    push_node(tbl[0]);
    run_req(3);
    drain();

    // seed_req and req_valid together: seed first, request afterwards
    push_beat(5, 0, 1'b1, 1'b0);
    push_beat(9, 0, 1'b1, 1'b0);
    push_node(tbl[3]);
    seed_req = 1'b1; req_valid = 1'b1; req_node = 10'd1;
    tick();
    seed_req = 1'b0;
    check("prio_seed_first", {30'd0, next_valid, next_is_seed}, 32'd3);
    begin
      int n = 0;
      while (!req_ready && n < 50) begin
        tick();
        n++;
      end
    end
    check("prio_back_idle", {31'd0, req_ready}, 32'd1);
    tick();
    req_valid = 1'b0;
    drain();

    // Reset in the middle of a stream, then a fresh request
    push_node(tbl[0]);
    run_req(3);
    tick();
    rst = 1'b1;
    tick();
    check("rst_mid_valid", {31'd0, next_valid}, 32'd0);
    rst = 1'b0;
    exp_q.delete();
    tick();
    push_node(tbl[0]);
    run_req(3);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
